// File: rtl/spin_sweep_ctrl.sv
// Metropolis sweep controller for an 8x8 toroidal Ising lattice driving an external acceptance LUT.
// Each site takes 3 cycles (CALC, EVAL, UPDATE); an N-sweep run is 192*N cycles from CALC entry to DONE.
module spin_sweep_ctrl #(
  parameter logic [11:0] LFSR_SEED = 12'hACE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  n_sweeps,
  output logic [4:0]  dE,
  output logic [11:0] random,
  output logic        enable,
  input  logic        result,
  output logic        busy,
  output logic        done,
  output logic [15:0] flip_count,
  input  logic [5:0]  rd_addr,
  output logic        rd_spin
);

  typedef enum logic [2:0] {IDLE, CALC, EVAL, UPDATE, DONE} state_t;

  state_t      state_q;
  logic [63:0] spin_q;
  logic [11:0] lfsr_q;
  logic [5:0]  site_q;
  logic [7:0]  sweep_q;
  logic        res_q;
  logic [15:0] flips_q;
  logic [4:0]  de_q;
  logic [11:0] rnd_q;
  logic        en_q;
  logic        busy_q;
  logic        done_q;

  logic [2:0]  row, col, row_up, row_dn, col_lt, col_rt;
  logic [2:0]  nb_cnt;
  logic [4:0]  nb_sum;
  logic [4:0]  de_d;
  logic [11:0] lfsr_d;

  assign row    = site_q[5:3];
  assign col    = site_q[2:0];
  assign row_up = row - 3'd1;
  assign row_dn = row + 3'd1;
  assign col_lt = col - 3'd1;
  assign col_rt = col + 3'd1;

  // Neighbour sum in +/-1 terms is 2*(number of up spins) - 4.
  assign nb_cnt = {2'b00, spin_q[{row_up, col}]} + {2'b00, spin_q[{row_dn, col}]}
                + {2'b00, spin_q[{row, col_lt}]} + {2'b00, spin_q[{row, col_rt}]};
  assign nb_sum = {1'b0, nb_cnt, 1'b0} - 5'd4;
  assign de_d   = spin_q[site_q] ? nb_sum : (5'd0 - nb_sum);

  // x^12 + x^11 + x^10 + x^4 + 1, feedback enters at the LSB.
  assign lfsr_d = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[9] ^ lfsr_q[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      spin_q  <= '1;
      lfsr_q  <= LFSR_SEED;
      site_q  <= '0;
      sweep_q <= '0;
      res_q   <= 1'b0;
      flips_q <= '0;
      de_q    <= '0;
      rnd_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (n_sweeps != 8'd0) begin
              site_q  <= '0;
              sweep_q <= n_sweeps;
              state_q <= CALC;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        CALC: begin
          de_q    <= de_d;
          rnd_q   <= lfsr_q;
          en_q    <= 1'b1;
          state_q <= EVAL;
        end
        EVAL: begin
          res_q   <= result;
          en_q    <= 1'b0;
          state_q <= UPDATE;
        end
        UPDATE: begin
          if (res_q) begin
            spin_q[site_q] <= ~spin_q[site_q];
            flips_q        <= flips_q + 16'd1;
          end
          lfsr_q  <= lfsr_d;
          site_q  <= site_q + 6'd1;
          state_q <= CALC;
          if (site_q == 6'd63) begin
            sweep_q <= sweep_q - 8'd1;
            if (sweep_q == 8'd1) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dE         = de_q;
  assign random     = rnd_q;
  assign enable     = en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign flip_count = flips_q;
  assign rd_spin    = spin_q[rd_addr];

endmodule

// File: tb/tb_spin_sweep_ctrl.sv
// Bench for spin_sweep_ctrl: a lattice/LFSR reference model predicts dE, random, flips and spins,
// while the bench itself plays the acceptance LUT in several modes.
module tb_spin_sweep_ctrl;

  localparam logic [11:0] SEED = 12'hACE;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  n_sweeps;
  logic [4:0]  dE;
  logic [11:0] random;
  logic        enable;
  logic        result;
  logic        busy;
  logic        done;
  logic [15:0] flip_count;
  logic [5:0]  rd_addr;
  logic        rd_spin;

  spin_sweep_ctrl #(.LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_sweeps(n_sweeps),
    .dE(dE), .random(random), .enable(enable), .result(result),
    .busy(busy), .done(done), .flip_count(flip_count),
    .rd_addr(rd_addr), .rd_spin(rd_spin)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // LUT modes: 0 never flip, 1 flip only site 0, 2 Metropolis table, 3 random bit every cycle.
  int   mode      = 0;
  int   cur_site  = 0;
  logic noise_bit = 1'b0;

  // Reference model state.
  int          mspin [64];
  logic [11:0] mlfsr;
  logic [15:0] mflips;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] lut_prob(input logic [4:0] e);
    case (e)
      5'd2:    return 12'h2A0;
      5'd4:    return 12'h070;
      default: return 12'hFFF;
    endcase
  endfunction

  always_comb begin
    result = 1'b0;
    case (mode)
      1:       result = enable && (cur_site == 0);
      2:       result = enable && (random <= lut_prob(dE));
      3:       result = noise_bit;
      default: result = 1'b0;
    endcase
  end

  function automatic logic [11:0] lfsr_next(input logic [11:0] v);
    logic fb;
    fb = ^(v & 12'hE08);
    return {v[10:0], fb};
  endfunction

  function automatic int model_de(input int site);
    int r, c, sum;
    r   = site / 8;
    c   = site % 8;
    sum = mspin[((r + 7) % 8) * 8 + c] + mspin[((r + 1) % 8) * 8 + c]
        + mspin[r * 8 + (c + 7) % 8] + mspin[r * 8 + (c + 1) % 8];
    return mspin[site] * sum;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mspin[i] = 1;
    mlfsr  = SEED;
    mflips = '0;
  endtask

  // Reads the whole lattice through rd_addr; only used while the block is not sweeping.
  task automatic check_lattice(input string tag);
    logic [63:0] got, exp;
    for (int i = 0; i < 64; i++) begin
      rd_addr = i[5:0];
      #1;
      got[i] = rd_spin;
      exp[i] = (mspin[i] == 1);
    end
    chk({tag, "_lo"}, got[31:0], exp[31:0]);
    chk({tag, "_hi"}, got[63:32], exp[63:32]);
    @(negedge clk);
  endtask

  task automatic run(input int n, input int md, input bit noisy, input int abort_at);
    int          t0;
    int          d;
    logic [4:0]  exp_de;
    logic        acc;
    mode     = md;
    start    = 1'b1;
    n_sweeps = n[7:0];
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
    if (n == 0) begin
      chk("zero_done", {29'd0, busy, done, enable}, 32'b110);
      @(negedge clk);
      chk("zero_idle", {29'd0, busy, done, enable}, 32'b000);
      return;
    end
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < 64; i++) begin
        cur_site = i;
        if (noisy) begin
          start    = 1'($urandom % 2);
          n_sweeps = 8'($urandom);
        end
        noise_bit = 1'($urandom % 2);
        rd_addr   = 6'($urandom % 64);
        #1;
        chk("calc_ctl", {29'd0, busy, done, enable}, 32'b100);
        chk("rd_spin_mid", {31'd0, rd_spin}, {31'd0, mspin[rd_addr] == 1});
        @(negedge clk);
        if (s == 0 && i == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk("abort_ctl", {29'd0, busy, done, enable}, 32'b000);
          chk("abort_flips", {16'd0, flip_count}, 32'd0);
          chk("abort_dE", {27'd0, dE}, 32'd0);
          model_reset();
          check_lattice("abort_lattice");
          start = 1'b0;
          rst_n = 1'b1;
          for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_idle", {29'd0, busy, done, enable}, 32'b000);
          end
          return;
        end
        noise_bit = 1'($urandom % 2);
        #1;
        d      = model_de(i);
        exp_de = d[4:0];
        chk("eval_ctl", {29'd0, busy, done, enable}, 32'b101);
        chk("eval_dE", {27'd0, dE}, {27'd0, exp_de});
        chk("eval_random", {20'd0, random}, {20'd0, mlfsr});
        case (md)
          1:       acc = (i == 0);
          2:       acc = (mlfsr <= lut_prob(exp_de));
          3:       acc = noise_bit;
          default: acc = 1'b0;
        endcase
        if (md == 2) chk("lut_accept", {31'd0, result}, {31'd0, acc});
        @(negedge clk);
        noise_bit = 1'($urandom % 2);
        chk("update_ctl", {29'd0, busy, done, enable}, 32'b100);
        if (acc) begin
          mspin[i] = -mspin[i];
          mflips   = mflips + 16'd1;
        end
        mlfsr = lfsr_next(mlfsr);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("done_ctl", {29'd0, busy, done, enable}, 32'b110);
    chk("run_len", cyc - t0, 192 * n);
    chk("flips", {16'd0, flip_count}, {16'd0, mflips});
    @(negedge clk);
    chk("end_idle", {29'd0, busy, done, enable}, 32'b000);
    @(negedge clk);
    chk("stay_idle", {29'd0, busy, done, enable}, 32'b000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    n_sweeps = 8'd0;
    rd_addr  = 6'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ctl", {29'd0, busy, done, enable}, 32'b000);
    chk("rst_dE", {27'd0, dE}, 32'd0);
    chk("rst_random", {20'd0, random}, 32'd0);
    chk("rst_flips", {16'd0, flip_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_lattice("rst_lattice");

    // Never flip: every EVAL sees dE=4 and the first random is the seed.
    run(1, 0, 1'b0, -1);
    check_lattice("nf_lattice");

    // Flip only site 0: neighbours of site 0 then see dE=2.
    do_reset();
    run(1, 1, 1'b0, -1);
    rd_addr = 6'd0;
    #1;
    chk("site0_flipped", {31'd0, rd_spin}, 32'd0);
    check_lattice("s0_lattice");

    // Zero sweeps: immediate done, nothing else moves.
    run(0, 0, 1'b0, -1);
    check_lattice("zero_lattice");

    // Start/n_sweeps toggling throughout a two-sweep run with random LUT answers.
    run(2, 3, 1'b1, -1);
    check_lattice("noisy_lattice");

    // Metropolis table over four sweeps.
    run(4, 2, 1'b0, -1);
    check_lattice("lut_lattice");

    // Reset while site 20 is being evaluated.
    run(1, 3, 1'b0, 20);

    // The block runs normally again after the abort.
    run(1, 2, 1'b0, -1);
    check_lattice("post_abort_lattice");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
